// File: rtl/afc_ctrl.sv
// Automatic frequency control loop: counts sig_in edges per gate window and
// steers the LO tuning word through sweep (ACQ), correction (TRACK) and LOCK.
module afc_ctrl #(
  parameter int          GATE_CYC   = 250000,
  parameter logic [31:0] TARGET_CNT = 32'd10700,
  parameter logic [31:0] WIN_LO     = 32'd10600,
  parameter logic [31:0] WIN_HI     = 32'd10800,
  parameter logic [31:0] K_STEP     = 32'd8590,
  parameter logic [31:0] F_INIT     = 32'd324699527,
  parameter logic [31:0] SWEEP_STEP = 32'd2147484,
  parameter logic [31:0] SWEEP_SPAN = 32'd21474836,
  parameter logic [31:0] LOCK_TOL   = 32'd2,
  parameter int          LOCK_N     = 4
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sig_in,
  output logic [31:0] lo_fre,
  output logic [31:0] meas_cnt,
  output logic        meas_valid,
  output logic        locked,
  output logic [1:0]  state
);
  localparam int GW  = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam int GDW = $clog2(LOCK_N + 1);
  localparam logic [31:0] SW_MAX = F_INIT + SWEEP_SPAN;
  localparam logic [31:0] SW_MIN = F_INIT - SWEEP_SPAN;

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2, LOCK = 2'd3} state_t;

  state_t           st, st_nxt;
  logic [2:0]       sync;
  logic [1:0]       prime;
  logic [GW-1:0]    gate;
  logic [31:0]      edge_cnt, cnt_inc;
  logic [GDW-1:0]   good, good_nxt;
  logic [31:0]      lo_nxt, sweep, corr;
  logic signed [31:0] err;
  logic             strobe, run, close, in_win, in_tol;

  assign state  = st;
  assign locked = (st == LOCK);

  // Strobe is suppressed until the synchronizer has shifted out its reset zeros.
  assign strobe  = sync[1] & ~sync[2] & (prime == 2'd3);
  assign run     = enable && (st != IDLE);
  assign close   = run && (gate == GW'(GATE_CYC - 1));
  assign cnt_inc = (strobe && edge_cnt != 32'hFFFF_FFFF) ? edge_cnt + 32'd1 : edge_cnt;

  assign err    = $signed(meas_cnt - TARGET_CNT);
  assign corr   = 32'(err * $signed(K_STEP));
  assign in_win = (meas_cnt >= WIN_LO) && (meas_cnt <= WIN_HI);
  assign in_tol = (err <= $signed(LOCK_TOL)) && (err >= -$signed(LOCK_TOL));
  assign sweep  = lo_fre + SWEEP_STEP;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      prime <= '0;
    end else begin
      sync <= {sync[1:0], sig_in};
      if (prime != 2'd3) prime <= prime + 2'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      gate       <= '0;
      edge_cnt   <= '0;
      meas_cnt   <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= close;
      if (!run) begin
        gate     <= '0;
        edge_cnt <= '0;
      end else if (close) begin
        gate     <= '0;
        edge_cnt <= '0;
        meas_cnt <= cnt_inc;
      end else begin
        gate     <= gate + GW'(1);
        edge_cnt <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      lo_fre <= F_INIT;
      good   <= '0;
    end else begin
      st     <= st_nxt;
      lo_fre <= lo_nxt;
      good   <= good_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    lo_nxt   = lo_fre;
    good_nxt = good;
    if (!enable) begin
      st_nxt   = IDLE;
      lo_nxt   = F_INIT;
      good_nxt = '0;
    end else begin
      case (st)
        IDLE: begin
          st_nxt   = ACQ;
          lo_nxt   = F_INIT;
          good_nxt = '0;
        end
        ACQ: if (meas_valid) begin
          if (in_win) st_nxt = TRACK;
          else        lo_nxt = (sweep > SW_MAX) ? SW_MIN : sweep;
        end
        TRACK: if (meas_valid) begin
          if (in_win) begin
            lo_nxt = lo_fre + corr;
            if (in_tol) begin
              good_nxt = good + GDW'(1);
              if (good + GDW'(1) >= GDW'(LOCK_N)) st_nxt = LOCK;
            end else begin
              good_nxt = '0;
            end
          end else begin
            st_nxt   = ACQ;
            lo_nxt   = F_INIT;
            good_nxt = '0;
          end
        end
        LOCK: if (meas_valid) begin
          if (in_win) begin
            lo_nxt = lo_fre + corr;
            if (!in_tol) begin
              st_nxt   = TRACK;
              good_nxt = '0;
            end
          end else begin
            st_nxt   = ACQ;
            lo_nxt   = F_INIT;
            good_nxt = '0;
          end
        end
        default: st_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_afc_ctrl.sv
// Directed bench for afc_ctrl with small verification parameters.
module tb_afc_ctrl;
  logic        clk_in = 1'b0;
  logic        rst_n, enable, sig_in;
  logic [31:0] lo_fre, meas_cnt;
  logic        meas_valid, locked;
  logic [1:0]  state;
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] F0 = 32'd1000000;

  afc_ctrl #(
    .GATE_CYC(1000), .TARGET_CNT(32'd100), .WIN_LO(32'd90), .WIN_HI(32'd110),
    .K_STEP(32'd10), .F_INIT(F0), .SWEEP_STEP(32'd1000), .SWEEP_SPAN(32'd3000),
    .LOCK_TOL(32'd2), .LOCK_N(4)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
    .lo_fre(lo_fre), .meas_cnt(meas_cnt), .meas_valid(meas_valid),
    .locked(locked), .state(state)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // n pulses (3 high / 3 low cycles) starting 50 cycles in, well inside one window
  task automatic pulses(input int n);
    repeat (50) @(negedge clk_in);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      repeat (3) @(negedge clk_in);
      sig_in = 1'b0;
      repeat (3) @(negedge clk_in);
    end
  endtask

  task automatic wait_mv();
    bit seen = 0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(posedge clk_in); #1;
      if (meas_valid) seen = 1;
    end
    if (!seen) chk("mv_timeout", 32'd0, 32'd1);
  endtask

  task automatic win(input int n, input logic [1:0] est, input logic [31:0] elo, input string tag);
    pulses(n);
    wait_mv();
    chk({tag, "_cnt"}, meas_cnt, 32'(n));
    @(posedge clk_in); #1;
    chk({tag, "_state"}, 32'(state), 32'(est));
    chk({tag, "_lo"}, lo_fre, elo);
  endtask

  initial begin
    int mv_seen;
    rst_n = 1'b0; enable = 1'b0; sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_lo", lo_fre, F0);
    chk("rst_cnt", meas_cnt, 32'd0);
    chk("rst_mv", 32'(meas_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("idle_hold", 32'(state), 32'd0);

    enable = 1'b1;
    @(posedge clk_in); #1;
    chk("to_acq", 32'(state), 32'd1);

    // acquisition, then four good windows to lock
    win(100, 2'd2, F0, "acq_in");
    win(100, 2'd2, F0, "trk1");
    win(100, 2'd2, F0, "trk2");
    win(100, 2'd2, F0, "trk3");
    win(100, 2'd3, F0, "trk4");
    chk("locked_hi", 32'(locked), 32'd1);

    win(120, 2'd1, F0, "lock_out");
    chk("locked_lo", 32'(locked), 32'd0);

    // sweep with wrap at F_INIT+SPAN
    win(0, 2'd1, 32'd1001000, "swp1");
    win(0, 2'd1, 32'd1002000, "swp2");
    win(0, 2'd1, 32'd1003000, "swp3");
    win(0, 2'd1, 32'd997000,  "swp_wrap");

    win(100, 2'd2, 32'd997000, "acq2");
    win(105, 2'd2, 32'd997050, "corr105");
    win(100, 2'd2, 32'd997050, "g1");
    win(100, 2'd2, 32'd997050, "g2");
    win(98,  2'd2, 32'd997030, "g3_tol");
    win(102, 2'd3, 32'd997050, "g4_lock");
    win(110, 2'd2, 32'd997150, "lock_hiedge");
    win(90,  2'd2, 32'd997050, "trk_loedge");
    win(89,  2'd1, F0,         "trk_out");

    // back to lock, then drop enable mid-window
    win(100, 2'd2, F0, "re_acq");
    win(100, 2'd2, F0, "re1");
    win(100, 2'd2, F0, "re2");
    win(100, 2'd2, F0, "re3");
    win(100, 2'd3, F0, "re4");
    pulses(40);
    @(negedge clk_in); enable = 1'b0;
    @(posedge clk_in); #1;
    chk("dis_state", 32'(state), 32'd0);
    chk("dis_lo", lo_fre, F0);
    chk("dis_locked", 32'(locked), 32'd0);
    mv_seen = 0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk_in); #1;
      if (meas_valid) mv_seen++;
    end
    chk("dis_no_mv", 32'(mv_seen), 32'd0);

    // async reset mid-window with non-default outputs
    @(negedge clk_in); enable = 1'b1;
    @(posedge clk_in); #1;
    chk("en2_acq", 32'(state), 32'd1);
    win(30, 2'd1, 32'd1001000, "pre_rst");
    pulses(20);
    @(posedge clk_in); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_lo", lo_fre, F0);
    chk("arst_cnt", meas_cnt, 32'd0);
    chk("arst_mv", 32'(meas_valid), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    @(negedge clk_in); rst_n = 1'b1;
    repeat (3) @(negedge clk_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/afc_ctrl.md
AFC_CTRL -- requirements
Module: afc_ctrl

Interface
REQ-001 Parameter GATE_CYC, 250000, gate window length in clk_in cycles.
REQ-002 Parameter TARGET_CNT, 10700, nominal sig_in rising edges per window.
REQ-003 Parameter WIN_LO / WIN_HI, 10600 / 10800, inclusive capture window on edge count.
REQ-004 Parameter K_STEP, 8590, tuning-word change per count of error.
REQ-005 Parameter F_INIT, 324699527, power-on/fallback LO tuning word.
REQ-006 Parameter SWEEP_STEP / SWEEP_SPAN, 2147484 / 21474836, acquisition sweep increment and half-span about F_INIT.
REQ-007 Parameter LOCK_TOL / LOCK_N, 2 / 4, lock error tolerance (counts) and required consecutive in-tolerance windows.
REQ-008 clk_in  input  1  sole clock, all logic on rising edge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 enable  input  1  1 = run AFC loop, 0 = hold in IDLE.
REQ-011 sig_in  input  1  asynchronous square wave under measurement.
REQ-012 lo_fre  output  32  LO tuning word to DDS.
REQ-013 meas_cnt  output  32  edge count of last completed window.
REQ-014 meas_valid  output  1  one-cycle pulse, meas_cnt updated.
REQ-015 locked  output  1  high only in state LOCK.
REQ-016 state  output  2  IDLE=0, ACQ=1, TRACK=2, LOCK=3.

Function
REQ-017 sig_in shall pass a 2-FF synchronizer plus one edge-detect register; a rising edge shall produce a one-cycle edge strobe 3 cycles after the input transition.
REQ-018 Gate counter shall run 0..GATE_CYC-1 while enable=1 and state!=IDLE, wrapping to 0; held at 0 otherwise.
REQ-019 Edge counter (32 bit) shall increment per strobe, saturate at 0xFFFFFFFF, and on the cycle gate counter = GATE_CYC-1 shall load meas_cnt with its value including that cycle's strobe and restart at 0.
REQ-020 meas_valid shall be high for exactly the cycle after the meas_cnt load; all state/lo_fre decisions shall use meas_cnt during that cycle and take effect on its closing edge.
REQ-021 err = signed(meas_cnt - TARGET_CNT); correction = err * K_STEP, truncated to 32 bits, added modulo 2^32 to lo_fre.
REQ-022 IDLE: lo_fre = F_INIT, counters cleared; enable=1 -> ACQ next cycle.
REQ-023 ACQ: on meas_valid, if WIN_LO <= meas_cnt <= WIN_HI -> TRACK with lo_fre unchanged; else lo_fre += SWEEP_STEP, and if the result exceeds F_INIT+SWEEP_SPAN, lo_fre = F_INIT-SWEEP_SPAN instead.
REQ-024 TRACK: on meas_valid, in window -> apply correction; if |err| <= LOCK_TOL increment good-counter, else clear it; good-counter reaching LOCK_N -> LOCK; out of window -> ACQ with lo_fre = F_INIT and good-counter cleared.
REQ-025 LOCK: on meas_valid, in window -> apply correction; |err| > LOCK_TOL -> TRACK, good-counter cleared; out of window -> ACQ, lo_fre = F_INIT.
REQ-026 enable=0 in any state -> IDLE on next edge, lo_fre = F_INIT, gate/edge/good counters cleared, partial window discarded, no meas_valid.
REQ-027 Edge strobe and window close in the same cycle: the strobe counts in the closing window.
REQ-028 Window boundaries inclusive: meas_cnt = WIN_LO or WIN_HI is in window.

Reset
REQ-029 rst_n=0 shall immediately force state=IDLE, lo_fre=F_INIT, meas_cnt=0, meas_valid=0, locked=0, all counters 0, synchronizer registers 0.
REQ-030 Release of rst_n shall be followed by synchronous operation from the next rising clk_in edge; no edge shall be counted from the reset value of the synchronizer.

Verification (GATE_CYC=1000, TARGET_CNT=100, WIN_LO=90, WIN_HI=110, K_STEP=10, F_INIT=1000000, SWEEP_STEP=1000, SWEEP_SPAN=3000, LOCK_TOL=2, LOCK_N=4)
REQ-031 enable=1, 100 edges/window for 5 windows -> ACQ->TRACK after window 1, LOCK after window 5, lo_fre stays 1000000, locked=1.
REQ-032 TRACK, window with 105 edges -> lo_fre += 50 two edges after window close, good-counter cleared.
REQ-033 ACQ, 0 edges/window -> lo_fre 1001000, 1002000, 1003000, then 997000 (wrap).
REQ-034 LOCK, window with 120 edges -> state ACQ, lo_fre = 1000000, locked=0.
REQ-035 enable dropped mid-window in LOCK -> IDLE next cycle, no meas_valid, lo_fre = 1000000.
REQ-036 rst_n asserted asynchronously mid-window -> outputs at reset values before next clk_in edge.
